// File: rtl/residue_reader_luma16x16_if.sv
// Row stream from the luma 16x16 residue reader towards the forward transform stage.
interface residue_reader_luma16x16_if;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_row;
  logic [3:0]   out_row_idx;
  logic         out_last;
  logic [2:0]   out_mode;

  modport master (output out_valid, out_row, out_row_idx, out_last, out_mode, input out_ready);
  modport slave  (input out_valid, out_row, out_row_idx, out_last, out_mode, output out_ready);
endinterface

// File: rtl/residue_reader_luma16x16.sv
// Fetches a stored 16x16 luma residue block plus its prediction mode and streams it row by row.
// Optional RESREAD_SUM_EN adds out_sum, the byte sum of the fetched block.
module residue_reader_luma16x16 #(
  parameter int FRAME_WIDTH  = 256,
  parameter int FRAME_HEIGHT = 256,
  parameter int ADDR_W       = 12,
  parameter int MB_W         = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MB_W-1:0]   mbnumber,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mode_rd_en,
  output logic [MB_W-1:0]   mode_rd_addr,
  input  logic [2:0]        mode_rd_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [127:0]      mem_rd_data,
`ifdef RESREAD_SUM_EN
  output logic [15:0]       out_sum,
`endif
  residue_reader_luma16x16_if.master os
);
  localparam int unsigned MBX = FRAME_WIDTH / 16;
  localparam int unsigned NMB = MBX * (FRAME_HEIGHT / 16);

  typedef enum logic [2:0] {S_IDLE, S_MODE, S_FETCH, S_DRAIN, S_FIN, S_REJECT} state_t;

  state_t            state_reg, state_next;
  logic [MB_W-1:0]   mb_reg;
  logic [3:0]        row_cnt_reg;
  logic              inflight_reg;
  logic [3:0]        inflight_idx_reg;
  logic              mode_pend_reg;
  logic [2:0]        mode_reg;
  logic [132:0]      fifo_mem [4];
  logic [1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [2:0]        fifo_cnt_reg;
  logic [132:0]      head;
  logic              pop;
  logic [3:0]        occupancy;
  logic [31:0]       mb_row_w, mb_col_w;
  logic              accept;

  assign accept   = (state_reg == S_IDLE) && start;
  assign mb_row_w = 32'(mb_reg) / MBX;
  assign mb_col_w = 32'(mb_reg) % MBX;
  assign mem_rd_addr  = ADDR_W'((mb_row_w * 32'd16 + 32'(row_cnt_reg)) * MBX + mb_col_w);
  assign mode_rd_addr = mb_reg;

  // Head of the FIFO is shown only while it holds data so idle outputs stay at zero.
  assign head            = fifo_mem[rd_ptr_reg];
  assign os.out_valid    = (fifo_cnt_reg != 3'd0);
  assign os.out_row      = os.out_valid ? head[127:0]   : '0;
  assign os.out_row_idx  = os.out_valid ? head[131:128] : '0;
  assign os.out_last     = os.out_valid ? head[132]     : 1'b0;
  assign os.out_mode     = mode_reg;
  assign pop             = os.out_valid && os.out_ready;

  // Slots already committed (buffered or returning) after this cycle's pop.
  assign occupancy = {1'b0, fifo_cnt_reg} + {3'b0, inflight_reg} - {3'b0, pop};

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != S_IDLE);
    done       = 1'b0;
    err        = 1'b0;
    mode_rd_en = 1'b0;
    mem_rd_en  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = (32'(mbnumber) >= NMB) ? S_REJECT : S_MODE;
      end
      S_MODE: begin
        mode_rd_en = 1'b1;
        state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_rd_en = (occupancy < 4'd4);
        if (mem_rd_en && row_cnt_reg == 4'd15) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!inflight_reg && (fifo_cnt_reg == 3'd0 || (fifo_cnt_reg == 3'd1 && pop)))
          state_next = S_FIN;
      end
      S_FIN: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_REJECT: begin
        done       = 1'b1;
        err        = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= S_IDLE;
      mb_reg           <= '0;
      row_cnt_reg      <= '0;
      inflight_reg     <= 1'b0;
      inflight_idx_reg <= '0;
      mode_pend_reg    <= 1'b0;
      mode_reg         <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      fifo_cnt_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      if (accept) row_cnt_reg <= '0;
      if (accept && state_next == S_MODE) mb_reg <= mbnumber;
      if (mem_rd_en) row_cnt_reg <= row_cnt_reg + 4'd1;
      inflight_reg     <= mem_rd_en;
      inflight_idx_reg <= row_cnt_reg;
      mode_pend_reg    <= mode_rd_en;
      if (mode_pend_reg) mode_reg <= mode_rd_data;
      if (inflight_reg) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop) rd_ptr_reg <= rd_ptr_reg + 2'd1;
      fifo_cnt_reg <= fifo_cnt_reg + {2'b0, inflight_reg} - {2'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (inflight_reg)
      fifo_mem[wr_ptr_reg] <= {(inflight_idx_reg == 4'd15), inflight_idx_reg, mem_rd_data};
  end

`ifdef RESREAD_SUM_EN
  logic [7:0]  byte_w [16];
  logic [11:0] row_sum;
  logic [15:0] sum_reg;

  for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
    assign byte_w[gi] = mem_rd_data[gi*8 +: 8];
  end

  always_comb begin
    row_sum = '0;
    for (int i = 0; i < 16; i++) row_sum = row_sum + 12'(byte_w[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            sum_reg <= '0;
    else if (accept)       sum_reg <= '0;
    else if (inflight_reg) sum_reg <= sum_reg + 16'(row_sum);
  end

  assign out_sum = sum_reg;
`endif
endmodule

// File: tb/tb_residue_reader_luma16x16.sv
// Scoreboard bench for residue_reader_luma16x16: directed blocks, backpressure, reject and abort.
module tb_residue_reader_luma16x16;
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [8:0]   mbnumber;
  logic         busy, done, err, mode_rd_en, mem_rd_en;
  logic [8:0]   mode_rd_addr;
  logic [2:0]   mode_rd_data;
  logic [11:0]  mem_rd_addr;
  logic [127:0] mem_rd_data;
`ifdef RESREAD_SUM_EN
  logic [15:0]  out_sum;
`endif

  residue_reader_luma16x16_if os_if();

  residue_reader_luma16x16 dut (
    .clk(clk), .reset(reset), .start(start), .mbnumber(mbnumber),
    .busy(busy), .done(done), .err(err),
    .mode_rd_en(mode_rd_en), .mode_rd_addr(mode_rd_addr), .mode_rd_data(mode_rd_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
`ifdef RESREAD_SUM_EN
    .out_sum(out_sum),
`endif
    .os(os_if)
  );

  always #5 clk = ~clk;

  typedef struct {logic [127:0] row; logic [3:0] idx; logic last; logic [2:0] mode;} row_t;
  typedef struct {logic err; int cyc; int sum;} done_t;

  logic [127:0] res_ram [4096];
  logic [2:0]   mode_ram [512];
  row_t         row_q[$];
  logic [11:0]  addr_q[$];
  done_t        done_q[$];
  logic [11:0]  obs_addr[$];

  int checks = 0, failures = 0;
  int cyc = 0;
  int mode_expected = 0, exp_mode_addr = 0;
  int exp_mode_cyc = -1, exp_mem_cyc = -1, exp_valid_cyc = -1;
  int issued = 0, accepted = 0, max_out = 0, rows_acc = 0, stall_cnt = 0;
  bit bp_on = 0;
  bit prev_stall = 0;
  logic [127:0] prev_row;
  logic [3:0]   prev_idx;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_rd_en)  mem_rd_data  <= res_ram[mem_rd_addr];
    if (mode_rd_en) mode_rd_data <= mode_ram[mode_rd_addr];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Downstream ready: held high, or the 1,0,0,1 pattern while backpressure is on.
  initial begin
    int ph = 0;
    os_if.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_on) begin
        os_if.out_ready = (ph % 4 == 0) || (ph % 4 == 3);
        ph++;
      end else begin
        os_if.out_ready = 1'b1;
        ph = 0;
      end
    end
  end

  // Monitor: pops the scoreboard queues whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 0;
    end else begin
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (mode_rd_en) begin
        chk("mode_rd_expected", mode_expected != 0, 1);
        if (mode_expected > 0) mode_expected--;
        chk("mode_rd_addr", mode_rd_addr, exp_mode_addr);
        if (exp_mode_cyc >= 0) begin chk("mode_rd_cycle", cyc, exp_mode_cyc); exp_mode_cyc = -1; end
      end
      if (mem_rd_en) begin
        issued++;
        obs_addr.push_back(mem_rd_addr);
        chk("mem_rd_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) chk("mem_rd_addr", mem_rd_addr, addr_q.pop_front());
        if (exp_mem_cyc >= 0) begin chk("first_mem_rd_cycle", cyc, exp_mem_cyc); exp_mem_cyc = -1; end
      end
      if (os_if.out_valid && exp_valid_cyc >= 0) begin
        chk("first_valid_cycle", cyc, exp_valid_cyc);
        exp_valid_cyc = -1;
      end
      if (prev_stall) begin
        chk("stall_valid_held", os_if.out_valid, 1);
        chk("stall_row_held", os_if.out_row, prev_row);
        chk("stall_idx_held", os_if.out_row_idx, prev_idx);
      end
      if (os_if.out_valid && os_if.out_ready) begin
        row_t r;
        accepted++;
        rows_acc++;
        chk("row_expected", row_q.size() != 0, 1);
        if (row_q.size() != 0) begin
          r = row_q.pop_front();
          chk("out_row", os_if.out_row, r.row);
          chk("out_row_idx", os_if.out_row_idx, r.idx);
          chk("out_last", os_if.out_last, r.last);
          chk("out_mode", os_if.out_mode, r.mode);
        end
      end
      if (done) begin
        done_t d;
        chk("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) begin
          d = done_q.pop_front();
          chk("err", err, d.err);
          chk("busy_with_done", busy, 1);
          if (d.cyc >= 0) chk("done_cycle", cyc, d.cyc);
`ifdef RESREAD_SUM_EN
          if (d.sum >= 0) chk("out_sum", out_sum, d.sum);
`endif
        end
      end
      prev_stall = os_if.out_valid && !os_if.out_ready;
      if (prev_stall) stall_cnt++;
      prev_row = os_if.out_row;
      prev_idx = os_if.out_row_idx;
    end
  end

  task automatic start_block(input int mb, input bit bp, input int exp_sum);
    int t = cyc;
    if (mb >= 256) begin
      done_q.push_back('{1'b1, t + 1, exp_sum});
    end else begin
      for (int i = 0; i < 16; i++) begin
        logic [11:0] a = 12'(((mb / 16) * 16 + i) * 16 + (mb % 16));
        addr_q.push_back(a);
        row_q.push_back('{res_ram[a], 4'(i), (i == 15), mode_ram[mb]});
      end
      mode_expected = 1;
      exp_mode_addr = mb;
      exp_mode_cyc  = t + 1;
      exp_mem_cyc   = t + 2;
      exp_valid_cyc = t + 4;
      done_q.push_back('{1'b0, bp ? -1 : t + 20, exp_sum});
    end
    $display("start mb=%0d at cycle %0d", mb, t);
    start = 1'b1;
    mbnumber = 9'(mb);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (done_q.size() == 0 && row_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("block_completed", (done_q.size() == 0 && row_q.size() == 0), 1);
    chk("idle_after_block", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_mode_rd_en"}, mode_rd_en, 0);
    chk({tag, "_mem_rd_en"}, mem_rd_en, 0);
    chk({tag, "_mem_rd_addr"}, mem_rd_addr, 0);
    chk({tag, "_mode_rd_addr"}, mode_rd_addr, 0);
    chk({tag, "_out_valid"}, os_if.out_valid, 0);
    chk({tag, "_out_row"}, os_if.out_row, 0);
    chk({tag, "_out_row_idx"}, os_if.out_row_idx, 0);
    chk({tag, "_out_last"}, os_if.out_last, 0);
    chk({tag, "_out_mode"}, os_if.out_mode, 0);
`ifdef RESREAD_SUM_EN
    chk({tag, "_out_sum"}, out_sum, 0);
`endif
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    mbnumber = '0;
    for (int w = 0; w < 4096; w++) begin
      logic [11:0] wv = 12'(w);
      res_ram[w] = {16{wv[7:0]}};
    end
    for (int m = 0; m < 512; m++) mode_ram[m] = 3'((m + 2) % 8);

    repeat (3) @(posedge clk); #1;
    check_all_zero("reset");
    @(negedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    // Block 0: addresses 0,16..240, mode 2, full rate.
    obs_addr.delete();
    start_block(0, 0, -1);
    wait_idle(100);
    chk("t1_addr_count", obs_addr.size(), 16);
    if (obs_addr.size() == 16) begin
      chk("t1_first_addr", obs_addr[0], 12'd0);
      chk("t1_last_addr", obs_addr[15], 12'd240);
    end

    // Block 17 started in the cycle right after the previous done.
    obs_addr.delete();
    start_block(17, 0, -1);
    wait_idle(100);
    chk("t2_addr_count", obs_addr.size(), 16);
    if (obs_addr.size() == 16) begin
      chk("t2_first_addr", obs_addr[0], 12'd257);
      chk("t2_last_addr", obs_addr[15], 12'd497);
    end

    // Backpressure with ready pattern 1,0,0,1.
    bp_on = 1;
    max_out = 0;
    stall_cnt = 0;
    start_block(5, 1, -1);
    wait_idle(300);
    bp_on = 0;
    chk("max_outstanding_over_4", max_out > 4, 0);
    chk("stalls_seen", stall_cnt > 0, 1);

    // Out-of-range block is rejected without any RAM access.
    obs_addr.delete();
    start_block(256, 0, 0);
    wait_idle(20);
    repeat (3) @(posedge clk); #1;
    chk("reject_no_reads", obs_addr.size(), 0);

    // Asynchronous reset in the middle of a block.
    rows_acc = 0;
    start_block(2, 0, -1);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (rows_acc >= 8) break;
    end
    chk("abort_reached_row7", rows_acc >= 8, 1);
    #1 reset = 1'b0;
    #1 check_all_zero("abort");
    row_q.delete(); addr_q.delete(); done_q.delete();
    mode_expected = 0;
    exp_mode_cyc = -1; exp_mem_cyc = -1; exp_valid_cyc = -1;
    issued = 0; accepted = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 reset = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("abort_stays_idle", busy, 0);
    obs_addr.delete();
    start_block(3, 0, -1);
    wait_idle(100);
    chk("t5_addr_count", obs_addr.size(), 16);
    if (obs_addr.size() == 16) chk("t5_first_addr", obs_addr[0], 12'd3);

`ifdef RESREAD_SUM_EN
    for (int i = 0; i < 16; i++) res_ram[i * 16] = {16{8'h01}};
    start_block(0, 0, 256);
    wait_idle(100);
    for (int i = 0; i < 16; i++) res_ram[i * 16] = {16{8'hFF}};
    start_block(0, 0, 65280);
    wait_idle(100);
    chk("sum_held_after_done", out_sum, 16'd65280);
    start_block(300, 0, 0);
    wait_idle(20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
